irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Priority interrupt controller placed directly upstream of the multicycle processor core.
- Collects edge-triggered device interrupt lines and one non-maskable source.
- Drives the core's INT, NMI and INTD inputs and consumes the core's INA acknowledge.
- Supplies the serviced source ID and supports one level of NMI pre-emption of a maskable service.

Parameters:
- NUM_SRC, 8, number of maskable interrupt sources; index 0 is highest priority.
- ID_W, 3, width of the source ID; must satisfy 2**ID_W >= NUM_SRC.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- irq_src  in  NUM_SRC  device interrupt lines, synchronous to clk; a rising edge requests service.
- nmi_src  in  1  non-maskable line, synchronous to clk; a rising edge requests service.
- mask_we  in  1  write strobe for mask_wdata.
- mask_wdata  in  NUM_SRC  enable mask; 1 = source enabled.
- ovr_clr  in  1  clears all overrun bits.
- eoi  in  1  end-of-interrupt pulse from software/core.
- INA  in  1  acknowledge from the core.
- INT  out  1  maskable interrupt request to the core.
- NMI  out  1  non-maskable request to the core.
- INTD  out  1  high while any interrupt is in service.
- irq_id  out  ID_W  ID of the maskable source being requested or serviced.
- pending  out  NUM_SRC  latched pending bits.
- overrun  out  NUM_SRC  sticky bit per source: an edge arrived while that source was already pending.

Behaviour:
- Reset (async, rst_n=0) forces:
  - State IDLE.
  - INT=0, NMI=0, INTD=0, irq_id=0.
  - pending=0, overrun=0, nmi_pending=0, saved_int=0.
  - mask=0, so all maskable sources are disabled.
  - Edge-detect history registers = 0.
  - Reset mid-handshake abandons the request; no ack is remembered.
- Edge detection:
  - prev <= irq_src every cycle.
  - A source with irq_src=1 and prev=0 at an edge sets pending[i] at that edge.
  - If pending[i] is already 1 when a new edge arrives, set overrun[i].
  - nmi_src is handled the same way and sets nmi_pending.
- Mask:
  - On mask_we the mask loads mask_wdata.
  - The mask gates arbitration only; masked sources still latch pending.
- Arbitration: the lowest index i with pending[i] & mask[i] wins; NMI beats every maskable source.
- FSM (all outputs registered):
  - IDLE:
    - If nmi_pending: go to REQ_NMI and set NMI=1.
    - Else if any pending&mask: go to REQ_INT, latch irq_id=winner, set INT=1.
  - REQ_INT:
    - INT stays 1 and irq_id stays frozen until INA=1 is sampled, even if the mask changes.
    - On INA: clear pending[irq_id], set INT=0, set INTD=1, go to SVC_INT.
  - SVC_INT:
    - On eoi: set INTD=0 and go to IDLE.
    - Else if nmi_pending: set saved_int=1, NMI=1, go to REQ_NMI. INTD stays 1 and irq_id is held.
  - REQ_NMI:
    - On INA: clear nmi_pending, set NMI=0, set INTD=1, go to SVC_NMI.
  - SVC_NMI:
    - On eoi with saved_int=1: go to SVC_INT and clear saved_int.
    - On eoi with saved_int=0: go to IDLE and set INTD=0.
- Latency: a rising source edge sampled at edge k sets pending at k; INT/NMI go high at edge k+1, if the controller is in IDLE.
- Simultaneous events:
  - A new edge on source i in the same cycle as ack-clear of pending[i]: the set wins; pending stays 1 and overrun is not set.
  - ovr_clr coinciding with a new overrun: the set wins.
  - A new nmi edge in the same cycle as NMI ack: nmi_pending stays 1.
- Ignored inputs:
  - INA outside the REQ states.
  - eoi outside the SVC states.
  - Nested NMI during SVC_NMI; it stays pending until after eoi.
- INT and NMI are never both 1.

Test Plan:
- Reset, mask=0xFF, pulse irq_src[5] at edge k -> pending=0x20 at k; INT=1, irq_id=5 at k+1; INA -> INT=0, INTD=1, pending=0; eoi -> INTD=0.
- irq_src[6] and irq_src[2] rise in the same cycle, mask=0xFF -> irq_id=2 first; after INA and eoi, irq_id=6 is served.
- mask=0x00, pulse irq_src[1] -> pending=0x02, INT stays 0; write mask=0x02 -> INT=1, irq_id=1 the next cycle.
- During SVC_INT with irq_id=3, pulse nmi_src -> NMI=1, INTD=1; INA then eoi -> returns to SVC_INT with irq_id=3; second eoi -> IDLE, INTD=0.
- Pulse irq_src[4] twice before ack (mask=0) -> overrun=0x10; ovr_clr -> overrun=0.
- Drop rst_n while INT=1 in REQ_INT -> INT=0, pending=0, state IDLE immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/irq_controller_if.sv
// Core-side handshake of the interrupt controller.
// The controller drives INT/NMI/INTD/irq_id; the core returns INA and eoi.
interface irq_controller_if #(
  parameter int ID_W = 3
);
  logic            INT;
  logic            NMI;
  logic            INTD;
  logic [ID_W-1:0] irq_id;
  logic            INA;
  logic            eoi;

  modport master (output INT, NMI, INTD, irq_id, input INA, eoi);
  modport slave  (input INT, NMI, INTD, irq_id, output INA, eoi);
endinterface

// File: rtl/irq_controller.sv
// Priority interrupt controller: edge-latched sources, mask, fixed priority
// (index 0 highest), NMI with one level of pre-emption of a maskable service.

// Per-source edge detector with pending and sticky overrun bits.
module irq_src_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic src_i,
  input  logic clr_i,
  input  logic ovr_clr_i,
  output logic pend_o,
  output logic ovr_o
);
  logic prev_q, pend_q, ovr_q, pend_d, ovr_d, rise;

  assign rise = src_i & ~prev_q;

  // A new edge beats an ack-clear; overrun only when the old request survives.
  always_comb begin
    pend_d = rise | (pend_q & ~clr_i);
    ovr_d  = (rise & pend_q & ~clr_i) | (ovr_q & ~ovr_clr_i);
  end

  // Edge history, pending and overrun state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      prev_q <= src_i;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  assign pend_o = pend_q;
  assign ovr_o  = ovr_q;
endmodule

module irq_controller #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               nmi_src,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               ovr_clr,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] overrun,
  irq_controller_if.master   core
);
  typedef enum logic [2:0] {IDLE, REQ_INT, SVC_INT, REQ_NMI, SVC_NMI} state_t;

  state_t            state_q, state_d;
  logic              int_q, int_d, nmi_q, nmi_d, intd_q, intd_d;
  logic              saved_q, saved_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [NUM_SRC-1:0] mask_q, pend_clr, req;
  logic              nmi_prev_q, nmi_pend_q, nmi_clr;
  logic              ack_int, win_vld;
  logic [ID_W-1:0]   win_id;

  assign ack_int = (state_q == REQ_INT) & core.INA;
  assign nmi_clr = (state_q == REQ_NMI) & core.INA;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign pend_clr[i] = ack_int & (id_q == ID_W'(i));
    irq_src_cell u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .src_i    (irq_src[i]),
      .clr_i    (pend_clr[i]),
      .ovr_clr_i(ovr_clr),
      .pend_o   (pending[i]),
      .ovr_o    (overrun[i])
    );
  end

  assign req = pending & mask_q;

  // Fixed priority: scanning downward leaves the lowest requesting index.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(i);
      end
    end
  end

  // Mask register and NMI edge/pending; a fresh NMI edge survives its own ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q     <= '0;
      nmi_prev_q <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else begin
      if (mask_we) mask_q <= mask_wdata;
      nmi_prev_q <= nmi_src;
      nmi_pend_q <= (nmi_src & ~nmi_prev_q) | (nmi_pend_q & ~nmi_clr);
    end
  end

  // Next state and registered outputs; irq_id is held across NMI pre-emption.
  always_comb begin
    state_d = state_q;
    int_d   = int_q;
    nmi_d   = nmi_q;
    intd_d  = intd_q;
    saved_d = saved_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (nmi_pend_q) begin
          state_d = REQ_NMI;
          nmi_d   = 1'b1;
        end else if (win_vld) begin
          state_d = REQ_INT;
          id_d    = win_id;
          int_d   = 1'b1;
        end
      end
      REQ_INT: begin
        if (core.INA) begin
          int_d   = 1'b0;
          intd_d  = 1'b1;
          state_d = SVC_INT;
        end
      end
      SVC_INT: begin
        if (core.eoi) begin
          intd_d  = 1'b0;
          state_d = IDLE;
        end else if (nmi_pend_q) begin
          saved_d = 1'b1;
          nmi_d   = 1'b1;
          state_d = REQ_NMI;
        end
      end
      REQ_NMI: begin
        if (core.INA) begin
          nmi_d   = 1'b0;
          intd_d  = 1'b1;
          state_d = SVC_NMI;
        end
      end
      SVC_NMI: begin
        if (core.eoi) begin
          if (saved_q) begin
            saved_d = 1'b0;
            state_d = SVC_INT;
          end else begin
            intd_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      int_q   <= 1'b0;
      nmi_q   <= 1'b0;
      intd_q  <= 1'b0;
      saved_q <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      int_q   <= int_d;
      nmi_q   <= nmi_d;
      intd_q  <= intd_d;
      saved_q <= saved_d;
      id_q    <= id_d;
    end
  end

  assign core.INT    = int_q;
  assign core.NMI    = nmi_q;
  assign core.INTD   = intd_q;
  assign core.irq_id = id_q;
endmodule

// File: tb/tb_irq_controller.sv
// Directed vector table plus hand sequences for simultaneous-event corners
// and asynchronous reset during a request.
module tb_irq_controller;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_src, mask_wdata, pending, overrun;
  logic       nmi_src, mask_we, ovr_clr;
  int         total = 0;
  int         bad = 0;

  irq_controller_if #(.ID_W(3)) cif ();

  irq_controller #(.NUM_SRC(8), .ID_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_src   (irq_src),
    .nmi_src   (nmi_src),
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
    .ovr_clr   (ovr_clr),
    .pending   (pending),
    .overrun   (overrun),
    .core      (cif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] irq;
    logic       nmi, mwe;
    logic [7:0] mw;
    logic       oclr, eoi, ina;
    logic       eint, enmi, eintd;
    logic [2:0] eid;
    logic [7:0] epend, eovr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [7:0] irq, input logic nmi, input logic mwe,
                     input logic [7:0] mw, input logic oclr, input logic eoi,
                     input logic ina, input logic eint, input logic enmi,
                     input logic eintd, input logic [2:0] eid,
                     input logic [7:0] epend, input logic [7:0] eovr);
    vec_t v;
    v.irq = irq; v.nmi = nmi; v.mwe = mwe; v.mw = mw; v.oclr = oclr;
    v.eoi = eoi; v.ina = ina; v.eint = eint; v.enmi = enmi; v.eintd = eintd;
    v.eid = eid; v.epend = epend; v.eovr = eovr;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] irq, input logic nmi, input logic mwe,
                       input logic [7:0] mw, input logic oclr, input logic eoi,
                       input logic ina);
    irq_src = irq; nmi_src = nmi; mask_we = mwe; mask_wdata = mw;
    ovr_clr = oclr; cif.eoi = eoi; cif.INA = ina;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // INT and NMI must never be raised together.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cif.INT === 1'b1 && cif.NMI === 1'b1) begin
      bad++;
      $display("FAIL int_nmi_excl got=11 want=not both t=%0t", $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(8'h00, 0, 0, 8'h00, 0, 0, 0);
    //    irq  nmi mwe mw    oc eoi ina | INT NMI INTD id pend   ovr
    add(8'h00, 0, 1, 8'hFF, 0, 0, 0,   0, 0, 0, 0, 8'h00, 8'h00);
    add(8'h20, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 8'h20, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 0, 0,   1, 0, 0, 5, 8'h20, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 0, 0,   1, 0, 0, 5, 8'h20, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 0, 1,   0, 0, 1, 5, 8'h00, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 0, 0,   0, 0, 1, 5, 8'h00, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 1, 0,   0, 0, 0, 5, 8'h00, 8'h00);
    add(8'h44, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 5, 8'h44, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 0, 0,   1, 0, 0, 2, 8'h44, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 0, 1,   0, 0, 1, 2, 8'h40, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 1, 0,   0, 0, 0, 2, 8'h40, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 0, 0,   1, 0, 0, 6, 8'h40, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 0, 1,   0, 0, 1, 6, 8'h00, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 1, 0,   0, 0, 0, 6, 8'h00, 8'h00);
    add(8'h00, 0, 1, 8'h00, 0, 0, 0,   0, 0, 0, 6, 8'h00, 8'h00);
    add(8'h02, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 6, 8'h02, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 6, 8'h02, 8'h00);
    add(8'h00, 0, 1, 8'h02, 0, 0, 0,   0, 0, 0, 6, 8'h02, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 0, 0,   1, 0, 0, 1, 8'h02, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 0, 1,   0, 0, 1, 1, 8'h00, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 1, 0,   0, 0, 0, 1, 8'h00, 8'h00);
    add(8'h00, 0, 1, 8'hFF, 0, 0, 0,   0, 0, 0, 1, 8'h00, 8'h00);
    add(8'h08, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 1, 8'h08, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 0, 0,   1, 0, 0, 3, 8'h08, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 0, 1,   0, 0, 1, 3, 8'h00, 8'h00);
    add(8'h00, 1, 0, 8'h00, 0, 0, 0,   0, 0, 1, 3, 8'h00, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 0, 0,   0, 1, 1, 3, 8'h00, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 0, 1,   0, 0, 1, 3, 8'h00, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 1, 0,   0, 0, 1, 3, 8'h00, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 1, 0,   0, 0, 0, 3, 8'h00, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 3, 8'h00, 8'h00);
    add(8'h00, 0, 1, 8'h00, 0, 0, 0,   0, 0, 0, 3, 8'h00, 8'h00);
    add(8'h10, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 3, 8'h10, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 3, 8'h10, 8'h00);
    add(8'h10, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 3, 8'h10, 8'h10);
    add(8'h00, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 3, 8'h10, 8'h10);
    add(8'h00, 0, 0, 8'h00, 1, 0, 0,   0, 0, 0, 3, 8'h10, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 1, 1,   0, 0, 0, 3, 8'h10, 8'h00);
    add(8'h00, 1, 1, 8'h10, 0, 0, 0,   0, 0, 0, 3, 8'h10, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 0, 0,   0, 1, 0, 3, 8'h10, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 0, 1,   0, 0, 1, 3, 8'h10, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 1, 0,   0, 0, 0, 3, 8'h10, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 0, 0,   1, 0, 0, 4, 8'h10, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 0, 1,   0, 0, 1, 4, 8'h00, 8'h00);
    add(8'h00, 0, 0, 8'h00, 0, 1, 0,   0, 0, 0, 4, 8'h00, 8'h00);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_INT", 32'(cif.INT), 0);
    chk("rst_NMI", 32'(cif.NMI), 0);
    chk("rst_INTD", 32'(cif.INTD), 0);
    chk("rst_id", 32'(cif.irq_id), 0);
    chk("rst_pend", 32'(pending), 0);
    chk("rst_ovr", 32'(overrun), 0);
    rst_n = 1'b1;
    step();

    foreach (vq[n]) begin
      drive(vq[n].irq, vq[n].nmi, vq[n].mwe, vq[n].mw, vq[n].oclr, vq[n].eoi, vq[n].ina);
      step();
      chk($sformatf("v%0d_INT", n), 32'(cif.INT), 32'(vq[n].eint));
      chk($sformatf("v%0d_NMI", n), 32'(cif.NMI), 32'(vq[n].enmi));
      chk($sformatf("v%0d_INTD", n), 32'(cif.INTD), 32'(vq[n].eintd));
      chk($sformatf("v%0d_id", n), 32'(cif.irq_id), 32'(vq[n].eid));
      chk($sformatf("v%0d_pend", n), 32'(pending), 32'(vq[n].epend));
      chk($sformatf("v%0d_ovr", n), 32'(overrun), 32'(vq[n].eovr));
    end

    // New edge on the source being acked: pending survives, no overrun.
    drive(8'h00, 0, 1, 8'hFF, 0, 0, 0); step();
    drive(8'h80, 0, 0, 8'h00, 0, 0, 0); step();
    drive(8'h00, 0, 0, 8'h00, 0, 0, 0); step();
    chk("ackset_INT", 32'(cif.INT), 1);
    chk("ackset_id", 32'(cif.irq_id), 7);
    drive(8'h80, 0, 0, 8'h00, 0, 0, 1); step();
    chk("ackset_pend", 32'(pending), 32'h80);
    chk("ackset_ovr", 32'(overrun), 0);
    chk("ackset_INTD", 32'(cif.INTD), 1);
    drive(8'h00, 0, 0, 8'h00, 0, 1, 0); step();
    chk("ackset_eoi", 32'(cif.INTD), 0);
    drive(8'h00, 0, 0, 8'h00, 0, 0, 0); step();
    chk("ackset_reINT", 32'(cif.INT), 1);
    drive(8'h00, 0, 0, 8'h00, 0, 0, 1); step();
    drive(8'h00, 0, 0, 8'h00, 0, 1, 0); step();
    chk("ackset_done", 32'(pending), 0);

    // New NMI edge during its ack: request stays pending and comes back.
    drive(8'h00, 1, 0, 8'h00, 0, 0, 0); step();
    drive(8'h00, 0, 0, 8'h00, 0, 0, 0); step();
    chk("nmiack_NMI", 32'(cif.NMI), 1);
    drive(8'h00, 1, 0, 8'h00, 0, 0, 1); step();
    chk("nmiack_NMI0", 32'(cif.NMI), 0);
    chk("nmiack_INTD", 32'(cif.INTD), 1);
    drive(8'h00, 0, 0, 8'h00, 0, 1, 0); step();
    chk("nmiack_eoi", 32'(cif.INTD), 0);
    drive(8'h00, 0, 0, 8'h00, 0, 0, 0); step();
    chk("nmiack_again", 32'(cif.NMI), 1);
    drive(8'h00, 0, 0, 8'h00, 0, 0, 1); step();
    drive(8'h00, 0, 0, 8'h00, 0, 1, 0); step();
    chk("nmiack_done", 32'({cif.NMI, cif.INTD}), 0);

    // ovr_clr in the same cycle as a new overrun: the set wins.
    drive(8'h00, 0, 1, 8'h00, 0, 0, 0); step();
    drive(8'h01, 0, 0, 8'h00, 0, 0, 0); step();
    drive(8'h00, 0, 0, 8'h00, 0, 0, 0); step();
    drive(8'h01, 0, 0, 8'h00, 1, 0, 0); step();
    chk("ovrclr_setwins", 32'(overrun), 32'h01);
    drive(8'h00, 0, 0, 8'h00, 1, 0, 0); step();
    chk("ovrclr_clear", 32'(overrun), 0);
    chk("ovrclr_pend", 32'(pending), 32'h01);

    // Async reset while INT is raised.
    drive(8'h00, 0, 1, 8'hFF, 0, 0, 0); step();
    drive(8'h00, 0, 0, 8'h00, 0, 0, 0); step();
    chk("arst_pre_INT", 32'(cif.INT), 1);
    chk("arst_pre_id", 32'(cif.irq_id), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_INT", 32'(cif.INT), 0);
    chk("arst_pend", 32'(pending), 0);
    chk("arst_INTD", 32'(cif.INTD), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    step();
    chk("arst_post_INT", 32'(cif.INT), 0);
    chk("arst_post_NMI", 32'(cif.NMI), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
